// File: rtl/reg_file_scoreboard_if.sv
// Decode / write-back bundle of the integer register file with scoreboard.
// master = pipeline side (decode + write-back), slave = register file.
interface reg_file_scoreboard_if #(
  parameter int XLEN = 32
);
  logic [4:0]      rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            rs1_ready, rs2_ready;

  logic            issue_valid;
  logic            issue_uses_rs1, issue_uses_rs2;
  logic            issue_wb_en;
  logic [4:0]      issue_rd;
  logic            stall;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_err;

  modport master (
    output rs1_addr, rs2_addr,
    output issue_valid, issue_uses_rs1, issue_uses_rs2, issue_wb_en, issue_rd,
    output wb_valid, wb_rd, wb_data,
    input  rs1_data, rs2_data, rs1_ready, rs2_ready, stall, wb_err
  );

  modport slave (
    input  rs1_addr, rs2_addr,
    input  issue_valid, issue_uses_rs1, issue_uses_rs2, issue_wb_en, issue_rd,
    input  wb_valid, wb_rd, wb_data,
    output rs1_data, rs2_data, rs1_ready, rs2_ready, stall, wb_err
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Integer register file x1..x31 with write-through bypass and a per-register
// outstanding-write counter that stalls issue on stale operands.
module reg_file_scoreboard #(
  parameter int XLEN     = 32,
  parameter int MAX_PEND = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  reg_file_scoreboard_if.slave   rf
);
  localparam int          NUM_RD   = 2;
  localparam logic [1:0]  PEND_MAX = 2'(MAX_PEND);

  logic [31:1][XLEN-1:0] regs_q;
  logic [31:1][1:0]      pend_q, pend_d;
  logic                  wb_err_q, wb_err_d;

  logic [NUM_RD-1:0][4:0]      rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]           rd_ready;

  logic       wb_live;
  logic [1:0] wb_pend;
  logic [1:0] iss_pend;
  logic       iss_full;
  logic       stall;
  logic       iss_acc;

  assign rd_addr[0] = rf.rs1_addr;
  assign rd_addr[1] = rf.rs2_addr;
  assign wb_live    = rf.wb_valid && (rf.wb_rd != 5'd0);

  // One lane per read port: stored value, bypass and readiness.
  genvar p;
  generate
    for (p = 0; p < NUM_RD; p++) begin : g_rd
      logic [XLEN-1:0] data;
      logic [1:0]      pend;
      logic            wb_hit;

      assign wb_hit = wb_live && (rf.wb_rd == rd_addr[p]);

      always_comb begin
        data = '0;
        pend = 2'd0;
        for (int r = 1; r < 32; r++) begin
          if (rd_addr[p] == r[4:0]) begin
            data = regs_q[r];
            pend = pend_q[r];
          end
        end
        if (wb_hit) data = rf.wb_data;
      end

      assign rd_data[p]  = data;
      // x0 lookups fall through to pend = 0, so x0 is always ready
      assign rd_ready[p] = (pend == 2'd0) || ((pend == 2'd1) && wb_hit);
    end
  endgenerate

  assign rf.rs1_data  = rd_data[0];
  assign rf.rs2_data  = rd_data[1];
  assign rf.rs1_ready = rd_ready[0];
  assign rf.rs2_ready = rd_ready[1];

  always_comb begin
    wb_pend  = 2'd0;
    iss_pend = 2'd0;
    for (int r = 1; r < 32; r++) begin
      if (rf.wb_rd == r[4:0])    wb_pend  = pend_q[r];
      if (rf.issue_rd == r[4:0]) iss_pend = pend_q[r];
    end
  end

  // A saturated destination may still issue when one of its writes retires now.
  assign iss_full = rf.issue_wb_en && (rf.issue_rd != 5'd0) &&
                    (iss_pend == PEND_MAX) &&
                    !(rf.wb_valid && (rf.wb_rd == rf.issue_rd));

  assign stall = rf.issue_valid &&
                 ((rf.issue_uses_rs1 && !rd_ready[0]) ||
                  (rf.issue_uses_rs2 && !rd_ready[1]) ||
                  iss_full);

  assign iss_acc = rf.issue_valid && !stall && rf.issue_wb_en &&
                   (rf.issue_rd != 5'd0);

  assign rf.stall  = stall;
  assign rf.wb_err = wb_err_q;

  always_comb begin
    pend_d   = pend_q;
    wb_err_d = wb_err_q;
    for (int r = 1; r < 32; r++) begin
      logic inc, dec;
      inc = iss_acc && (rf.issue_rd == r[4:0]);
      dec = rf.wb_valid && (rf.wb_rd == r[4:0]) && (pend_q[r] != 2'd0);
      if (inc && !dec)      pend_d[r] = pend_q[r] + 2'd1;
      else if (dec && !inc) pend_d[r] = pend_q[r] - 2'd1;
    end
    if (wb_live && (wb_pend == 2'd0)) wb_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q   <= '0;
      pend_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      wb_err_q <= wb_err_d;
      for (int r = 1; r < 32; r++) begin
        if (rf.wb_valid && (rf.wb_rd == r[4:0])) regs_q[r] <= rf.wb_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed + randomized bench for reg_file_scoreboard against an array-based
// architectural model of registers, outstanding-write counts and the error flag.
module tb_reg_file_scoreboard;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_file_scoreboard_if #(.XLEN(XLEN)) rf ();

  reg_file_scoreboard #(.XLEN(XLEN), .MAX_PEND(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [XLEN-1:0] mregs [32];
  int              mpend [32];
  bit              merr;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      mpend[i] = 0;
    end
    merr = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] m_data(logic [4:0] a);
    if (a == 5'd0) return '0;
    if (rf.wb_valid && rf.wb_rd == a) return rf.wb_data;
    return mregs[a];
  endfunction

  function automatic logic m_ready(logic [4:0] a);
    if (a == 5'd0) return 1'b1;
    if (mpend[a] == 0) return 1'b1;
    return (mpend[a] == 1) && rf.wb_valid && (rf.wb_rd == a);
  endfunction

  function automatic logic m_stall();
    logic full;
    if (!rf.issue_valid) return 1'b0;
    full = rf.issue_wb_en && rf.issue_rd != 5'd0 && mpend[rf.issue_rd] == 3 &&
           !(rf.wb_valid && rf.wb_rd == rf.issue_rd);
    return (rf.issue_uses_rs1 && !m_ready(rf.rs1_addr)) ||
           (rf.issue_uses_rs2 && !m_ready(rf.rs2_addr)) || full;
  endfunction

  task automatic chk(string tag, logic [XLEN-1:0] obs, logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".rs1_data"},  rf.rs1_data,  m_data(rf.rs1_addr));
    chk({tag, ".rs2_data"},  rf.rs2_data,  m_data(rf.rs2_addr));
    chk({tag, ".rs1_ready"}, XLEN'(rf.rs1_ready), XLEN'(m_ready(rf.rs1_addr)));
    chk({tag, ".rs2_ready"}, XLEN'(rf.rs2_ready), XLEN'(m_ready(rf.rs2_addr)));
    chk({tag, ".stall"},     XLEN'(rf.stall),     XLEN'(m_stall()));
    chk({tag, ".wb_err"},    XLEN'(rf.wb_err),    XLEN'(merr));
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cyc(string tag);
    bit acc, dec;
    logic [4:0] ird, wrd;
    #1 check_all(tag);
    acc = rf.issue_valid && !m_stall() && rf.issue_wb_en && rf.issue_rd != 5'd0;
    ird = rf.issue_rd;
    wrd = rf.wb_rd;
    dec = 1'b0;
    if (rf.wb_valid && wrd != 5'd0) begin
      if (mpend[wrd] == 0) merr = 1'b1;
      else dec = 1'b1;
      mregs[wrd] = rf.wb_data;
    end
    @(posedge clk);
    if (dec) mpend[wrd]--;
    if (acc) mpend[ird]++;
    @(negedge clk);
  endtask

  task automatic set_issue(bit v, bit u1, bit u2, bit we, logic [4:0] rd,
                           logic [4:0] a1, logic [4:0] a2);
    rf.issue_valid = v;  rf.issue_uses_rs1 = u1; rf.issue_uses_rs2 = u2;
    rf.issue_wb_en = we; rf.issue_rd = rd;
    rf.rs1_addr = a1;    rf.rs2_addr = a2;
  endtask

  task automatic set_wb(bit v, logic [4:0] rd, logic [XLEN-1:0] d);
    rf.wb_valid = v; rf.wb_rd = rd; rf.wb_data = d;
  endtask

  initial begin
    model_reset();
    set_issue(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, '0);
    rst_n = 1'b0;
    #1 check_all("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Every register reads zero and ready after reset
    for (int i = 0; i < 32; i++) begin
      set_issue(0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      cyc("rd_all");
    end

    // Writes to x0 are dropped, including the bypass path
    set_issue(0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 0, 32'hDEADBEEF);
    cyc("x0_wr");
    set_wb(0, 0, '0);
    cyc("x0_after");

    // Bypass then stored value for x5
    set_issue(1, 0, 0, 1, 5, 0, 0);
    cyc("x5_issue");
    set_issue(0, 0, 0, 0, 0, 5, 0);
    set_wb(1, 5, 32'h12345678);
    cyc("x5_bypass");
    set_wb(0, 0, '0);
    cyc("x5_stored");

    // Load-use hazard on x7
    set_issue(1, 0, 0, 1, 7, 0, 0);
    cyc("x7_issue");
    set_issue(1, 1, 0, 0, 0, 7, 0);
    cyc("x7_stall");
    cyc("x7_stall2");
    set_wb(1, 7, 32'hA5A5_0F0F);
    cyc("x7_retire");
    set_wb(0, 0, '0);
    set_issue(0, 0, 0, 0, 0, 7, 0);
    cyc("x7_after");

    // Saturate x3, full stall, issue alongside retire
    set_issue(1, 0, 0, 1, 3, 3, 0);
    repeat (3) cyc("x3_fill");
    cyc("x3_full");
    set_wb(1, 3, 32'h0000_0333);
    cyc("x3_swap");
    set_wb(0, 0, '0);
    cyc("x3_still_full");
    set_issue(0, 0, 0, 0, 0, 3, 0);
    for (int i = 0; i < 3; i++) begin
      set_wb(1, 3, 32'h3000 + i);
      cyc("x3_drain");
    end
    set_wb(0, 0, '0);
    cyc("x3_empty");

    // Simultaneous issue and retire on x9 with pend = 1
    set_issue(1, 0, 0, 1, 9, 0, 0);
    cyc("x9_issue");
    set_wb(1, 9, 32'h9999_0001);
    cyc("x9_both");
    set_issue(0, 0, 0, 0, 0, 9, 9);
    set_wb(0, 0, '0);
    cyc("x9_pending");
    set_wb(1, 9, 32'h9999_0002);
    cyc("x9_retire");
    set_wb(0, 0, '0);
    cyc("x9_done");

    // Unexpected write-back sets the sticky error
    set_issue(0, 0, 0, 0, 0, 12, 0);
    set_wb(1, 12, 32'h0C0C_0C0C);
    cyc("err_set");
    set_wb(0, 0, '0);
    cyc("err_sticky");
    cyc("err_sticky2");

    // Mid-operation reset clears everything at once
    set_issue(1, 0, 0, 1, 4, 0, 0);
    cyc("pre_rst_issue");
    set_issue(0, 0, 0, 0, 0, 12, 4);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst");

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      if (!m_stall()) begin
        set_issue($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
      end
      if ($urandom_range(0, 99) < 45) begin
        logic [4:0] w;
        w = 5'($urandom_range(0, 7));
        for (int t = 0; t < 8 && mpend[w] == 0; t++) w = 5'($urandom_range(0, 7));
        set_wb(1, w, $urandom);
      end else begin
        set_wb(0, 5'($urandom_range(0, 31)), $urandom);
      end
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
